// File: rtl/cola_buyer_pkg.sv
// Shared encodings for the cola buyer: FSM states, payment modes and the
// per-mode coin sequences that add up to one cola (price in half-yuan units).
package cola_buyer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_COIN = 3'd1,
    ST_GAP  = 3'd2,
    ST_WAIT = 3'd3,
    ST_NEXT = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MODE_HALF_END = 2'd0,
    MODE_ALL_HALF = 2'd1,
    MODE_ALL_ONE  = 2'd2,
    MODE_ALIAS    = 2'd3
  } mode_t;

  localparam int PRICE_HALF = 5;

  // Bit k set means coin k of the sequence is a 1-yuan coin, clear means 0.5.
  localparam logic [4:0] SEQ_HALF_END = 5'b00011;
  localparam logic [4:0] SEQ_ALL_HALF = 5'b00000;
  localparam logic [4:0] SEQ_ALL_ONE  = 5'b00111;

  function automatic mode_t norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_HALF_END : mode_t'(m);
  endfunction

  function automatic logic [2:0] seq_len(input mode_t m);
    case (m)
      MODE_ALL_HALF: return 3'(PRICE_HALF);
      default:       return 3'd3;
    endcase
  endfunction

  function automatic logic coin_is_one(input mode_t m, input logic [2:0] idx);
    logic [4:0] seq;
    case (m)
      MODE_ALL_HALF: seq = SEQ_ALL_HALF;
      MODE_ALL_ONE:  seq = SEQ_ALL_ONE;
      default:       seq = SEQ_HALF_END;
    endcase
    return seq[idx];
  endfunction

endpackage

// File: rtl/cola_buyer_timer.sv
// Loadable down-counter shared by the GAP and WAIT states; o_expire flags the
// last cycle of the loaded interval.
module cola_buyer_timer
  import cola_buyer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_val,
  output logic       o_expire
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_val;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (cnt_q == 8'd1);

endmodule

// File: rtl/cola_buyer.sv
// Buys i_cups colas from the vending FSM by pulsing coins per the chosen mode.
// Optional protocol checks enabled by defining COLA_BUYER_CHECK_EN.
module cola_buyer
  import cola_buyer_pkg::*;
#(
  parameter int GAP_CYC     = 1,
  parameter int TIMEOUT_CYC = 4
) (
  input  logic       i_sysclk,
  input  logic       i_sysrst,
  input  logic       i_start,
  input  logic [3:0] i_cups,
  input  logic [1:0] i_mode,
  input  logic       i_cola,
  input  logic       i_money,
  output logic       o_money_one,
  output logic       o_money_half,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [3:0] o_cola_cnt,
  output logic [3:0] o_change_cnt
);

  localparam logic [7:0] GAP_V     = 8'(GAP_CYC);
  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_CYC);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cups_q;
  mode_t      mode_q;
  logic       one_q, one_d, half_q, half_d;
  logic       busy_q, done_q, err_q;
  logic [3:0] cola_q, chg_q;

  logic       emit;
  mode_t      emit_mode;
  logic [2:0] emit_idx;
  logic       tmr_load, tmr_expire;
  logic [7:0] tmr_val;
  logic       accept, cola_inc, timeout, chk_err;

  cola_buyer_timer u_timer (
    .i_clk    (i_sysclk),
    .i_rst    (i_sysrst),
    .i_load   (tmr_load),
    .i_val    (tmr_val),
    .o_expire (tmr_expire)
  );

  // Coin registers are set on the transition into COIN so the pulse lines up
  // with the COIN cycle itself.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    emit      = 1'b0;
    emit_mode = mode_q;
    emit_idx  = idx_q;
    tmr_load  = 1'b0;
    tmr_val   = 8'd0;
    accept    = 1'b0;
    cola_inc  = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          accept = 1'b1;
          idx_d  = 3'd0;
          if (i_cups == 4'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_COIN;
            emit      = 1'b1;
            emit_mode = norm_mode(i_mode);
            emit_idx  = 3'd0;
          end
        end
      end
      ST_COIN: begin
        if (idx_q == seq_len(mode_q) - 3'd1) begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT_V;
        end else begin
          idx_d = idx_q + 3'd1;
          if (GAP_CYC == 0) begin
            state_d  = ST_COIN;
            emit     = 1'b1;
            emit_idx = idx_q + 3'd1;
          end else begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_V;
          end
        end
      end
      ST_GAP: begin
        if (tmr_expire) begin
          state_d = ST_COIN;
          emit    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (i_cola) begin
          state_d  = ST_NEXT;
          cola_inc = 1'b1;
        end else if (tmr_expire) begin
          state_d = ST_DONE;
          timeout = 1'b1;
        end
      end
      ST_NEXT: begin
        if (cola_q == cups_q) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_COIN;
          idx_d    = 3'd0;
          emit     = 1'b1;
          emit_idx = 3'd0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    one_d  = emit & coin_is_one(emit_mode, emit_idx);
    half_d = emit & ~coin_is_one(emit_mode, emit_idx);
  end

`ifdef COLA_BUYER_CHECK_EN
  logic money_seen_q;

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      money_seen_q <= 1'b0;
    end else if (state_d == ST_WAIT && state_q != ST_WAIT) begin
      money_seen_q <= 1'b0;
    end else if ((state_q == ST_WAIT || state_q == ST_NEXT) && i_money) begin
      money_seen_q <= 1'b1;
    end
  end

  // NEXT is the cycle after i_cola, the last chance for mode-2 change.
  always_comb begin
    chk_err = 1'b0;
    if (i_cola && state_q != ST_IDLE && state_q != ST_WAIT) chk_err = 1'b1;
    if (mode_q == MODE_ALL_ONE && state_q == ST_NEXT && !(money_seen_q || i_money)) chk_err = 1'b1;
    if (mode_q != MODE_ALL_ONE && state_q != ST_IDLE && i_money) chk_err = 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      one_q   <= 1'b0;
      half_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cola_q  <= 4'd0;
      chg_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      one_q   <= one_d;
      half_q  <= half_d;
      done_q  <= (state_q == ST_DONE);
      if (accept) begin
        busy_q <= 1'b1;
      end else if (state_q == ST_DONE) begin
        busy_q <= 1'b0;
      end
      if (accept) begin
        cola_q <= 4'd0;
        chg_q  <= 4'd0;
        err_q  <= 1'b0;
      end else begin
        if (cola_inc) cola_q <= cola_q + 4'd1;
        if (state_q != ST_IDLE && i_money && chg_q != 4'hF) chg_q <= chg_q + 4'd1;
        if (timeout || chk_err) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (accept) begin
      cups_q <= i_cups;
      mode_q <= norm_mode(i_mode);
    end
  end

  assign o_money_one  = one_q;
  assign o_money_half = half_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_cola_cnt   = cola_q;
  assign o_change_cnt = chg_q;

endmodule

// File: tb/tb_cola_buyer.sv
// Bench for cola_buyer: a vending-machine responder, a timeline model of the
// expected outputs per cycle, and hand-computed spot checks.
module tb_cola_buyer;

  localparam int GAP = 1;
  localparam int TO  = 4;
  localparam int N   = 1024;

  logic       clk = 1'b0;
  logic       rst, start, cola, money;
  logic [3:0] cups;
  logic [1:0] mode;
  logic       m_one, m_half, busy, done, err;
  logic [3:0] cola_cnt, chg_cnt;

  cola_buyer #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .i_sysclk     (clk),
    .i_sysrst     (rst),
    .i_start      (start),
    .i_cups       (cups),
    .i_mode       (mode),
    .i_cola       (cola),
    .i_money      (money),
    .o_money_one  (m_one),
    .o_money_half (m_half),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_cola_cnt   (cola_cnt),
    .o_change_cnt (chg_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per absolute cycle, written only by the stimulus process.
  logic e_one[N], e_half[N], e_busy[N], e_done[N], e_err[N];
  int   e_cola[N], e_chg[N];
  // Observed history, written only by the compare process.
  logic h_one[N], h_half[N], h_busy[N], h_done[N], h_err[N];

  typedef struct {int at; int kind; int a; int b; int exp;} lit_t;
  lit_t lits[$];

  int total = 0;
  int bad   = 0;

  bit vend_disp = 1'b1;
  int spur_cyc  = -1;

  // Vending machine: after 5 half-units of credit it dispenses one cycle
  // later, returning change alongside when overpaid.
  int credit = 0;
  bit pend = 1'b0, pend_chg = 1'b0;
  always @(negedge clk) begin
    cola  = pend;
    money = (pend & pend_chg) | (cyc == spur_cyc);
    pend  = 1'b0;
    if (!busy) credit = 0;
    else if (m_one) credit += 2;
    else if (m_half) credit += 1;
    if (credit >= 5) begin
      if (vend_disp) begin
        pend     = 1'b1;
        pend_chg = (credit > 5);
      end
      credit = 0;
    end
  end

  function automatic string kname(input int k);
    case (k)
      0: return "cola_cnt";
      1: return "change_cnt";
      2: return "err";
      3: return "one_coins";
      4: return "half_coins";
      5: return "busy_cycles";
      6: return "done_at";
      default: return "err_at";
    endcase
  endfunction

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < N) begin
      h_one[cyc]  = m_one;
      h_half[cyc] = m_half;
      h_busy[cyc] = busy;
      h_done[cyc] = done;
      h_err[cyc]  = err;
      total++;
      if ({m_one, m_half, busy, done, err, cola_cnt, chg_cnt} !==
          {e_one[cyc], e_half[cyc], e_busy[cyc], e_done[cyc], e_err[cyc],
           4'(e_cola[cyc]), 4'(e_chg[cyc])}) begin
        bad++;
        $display("FAIL cycle %0d outputs: got one=%b half=%b busy=%b done=%b err=%b cola=%0d chg=%0d, want one=%b half=%b busy=%b done=%b err=%b cola=%0d chg=%0d",
                 cyc, m_one, m_half, busy, done, err, cola_cnt, chg_cnt,
                 e_one[cyc], e_half[cyc], e_busy[cyc], e_done[cyc], e_err[cyc],
                 e_cola[cyc], e_chg[cyc]);
      end
      foreach (lits[i]) begin
        if (lits[i].at == cyc) begin
          int got;
          got = 0;
          case (lits[i].kind)
            0: got = int'(cola_cnt);
            1: got = int'(chg_cnt);
            2: got = int'(err);
            3: for (int j = lits[i].a; j <= lits[i].b; j++) got += int'(h_one[j]);
            4: for (int j = lits[i].a; j <= lits[i].b; j++) got += int'(h_half[j]);
            5: for (int j = lits[i].a; j <= lits[i].b; j++) got += int'(h_busy[j]);
            6: got = int'(h_done[lits[i].a]);
            default: got = int'(h_err[lits[i].a]);
          endcase
          total++;
          if (got != lits[i].exp) begin
            bad++;
            $display("FAIL spot %s at cycle %0d: got %0d want %0d",
                     kname(lits[i].kind), cyc, got, lits[i].exp);
          end
        end
      end
    end
  end

  task automatic lit(input int at, input int kind, input int a, input int b, input int exp);
    lit_t l;
    l.at = at; l.kind = kind; l.a = a; l.b = b; l.exp = exp;
    lits.push_back(l);
  endtask

  task automatic hold_from(input int sig, input int from, input int val);
    for (int i = from; i < N; i++) begin
      case (sig)
        0: e_cola[i] = val;
        1: e_chg[i]  = val;
        default: e_err[i] = (val != 0);
      endcase
    end
  endtask

  task automatic zero_from(input int from);
    for (int i = from; i < N; i++) begin
      e_one[i] = 0; e_half[i] = 0; e_busy[i] = 0; e_done[i] = 0;
      e_err[i] = 0; e_cola[i] = 0; e_chg[i] = 0;
    end
  endtask

  // Timeline of one purchase whose start is sampled at the edge ending cycle s0.
  task automatic model_purchase(input int s0, input int md, input int ncup);
    int m, len, t, done_t, colas;
    m      = (md == 3) ? 0 : md;
    len    = (m == 1) ? 5 : 3;
    hold_from(0, s0 + 1, 0);
    hold_from(1, s0 + 1, 0);
    hold_from(2, s0 + 1, 0);
    t      = s0 + 1;
    done_t = s0 + 2;
    colas  = 0;
    for (int c = 0; c < ncup; c++) begin
      for (int k = 0; k < len; k++) begin
        if (m == 2 || (m == 0 && k < 2)) e_one[t] = 1;
        else e_half[t] = 1;
        if (k < len - 1) t += GAP + 1;
      end
      if (!vend_disp) begin
        hold_from(2, t + TO + 1, 1);
        done_t = t + TO + 2;
        break;
      end
      colas++;
      hold_from(0, t + 2, colas);
      if (m == 2) hold_from(1, t + 2, colas);
      if (c == ncup - 1) done_t = t + 4;
      else t += 3;
    end
    for (int i = s0 + 1; i < done_t; i++) e_busy[i] = 1;
    e_done[done_t] = 1;
  endtask

  task automatic purchase(input int md, input int nc, output int s0);
    @(negedge clk);
    start = 1'b1;
    mode  = 2'(md);
    cups  = 4'(nc);
    s0    = cyc;
    model_purchase(s0, md, nc);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int s0;
    zero_from(0);
    rst = 1'b1; start = 1'b0; cups = 4'd0; mode = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lit(4, 5, 1, 3, 0);

    // mode 0, one cup
    purchase(0, 1, s0);
    lit(s0 + 20, 0, 0, 0, 1);
    lit(s0 + 20, 1, 0, 0, 0);
    lit(s0 + 20, 2, 0, 0, 0);
    lit(s0 + 20, 3, s0 + 1, s0 + 10, 2);
    lit(s0 + 20, 4, s0 + 1, s0 + 10, 1);
    lit(s0 + 20, 6, s0 + 9, 0, 1);
    repeat (20) @(negedge clk);

    // mode 2, two cups, change with every cola
    purchase(2, 2, s0);
    lit(s0 + 25, 3, s0 + 1, s0 + 20, 6);
    lit(s0 + 25, 0, 0, 0, 2);
    lit(s0 + 25, 1, 0, 0, 2);
    lit(s0 + 25, 2, 0, 0, 0);
    repeat (26) @(negedge clk);

    // mode 1, vending never dispenses
    vend_disp = 1'b0;
    purchase(1, 1, s0);
    lit(s0 + 20, 4, s0 + 1, s0 + 16, 5);
    lit(s0 + 20, 7, s0 + 13, 0, 0);
    lit(s0 + 20, 7, s0 + 14, 0, 1);
    lit(s0 + 20, 6, s0 + 15, 0, 1);
    lit(s0 + 20, 0, 0, 0, 0);
    repeat (22) @(negedge clk);
    vend_disp = 1'b1;

    // zero cups
    purchase(0, 0, s0);
    lit(s0 + 8, 6, s0 + 2, 0, 1);
    lit(s0 + 8, 5, s0, s0 + 6, 1);
    lit(s0 + 8, 3, s0, s0 + 6, 0);
    lit(s0 + 8, 4, s0, s0 + 6, 0);
    repeat (10) @(negedge clk);

    // reset during the second coin of a three-cup purchase
    purchase(0, 3, s0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    zero_from(s0 + 4);
    @(negedge clk);
    rst = 1'b0;
    lit(s0 + 14, 5, s0 + 4, s0 + 12, 0);
    lit(s0 + 14, 3, s0 + 4, s0 + 12, 0);
    lit(s0 + 14, 0, 0, 0, 0);
    repeat (12) @(negedge clk);
    purchase(2, 1, s0);
    lit(s0 + 15, 0, 0, 0, 1);
    lit(s0 + 15, 1, 0, 0, 1);
    lit(s0 + 15, 2, 0, 0, 0);
    repeat (16) @(negedge clk);

    // mode 3 aliases mode 0; a start while busy is ignored
    purchase(3, 2, s0);
    repeat (1) @(negedge clk);
    start = 1'b1; cups = 4'd1; mode = 2'd1;
    @(negedge clk);
    start = 1'b0;
    lit(s0 + 20, 6, s0 + 16, 0, 1);
    lit(s0 + 20, 0, 0, 0, 2);
    lit(s0 + 20, 4, s0 + 1, s0 + 16, 2);
    repeat (22) @(negedge clk);

    // mode 0 with a spurious change pulse during the first gap
    purchase(0, 1, s0);
    spur_cyc = s0 + 2;
    hold_from(1, s0 + 3, 1);
`ifdef COLA_BUYER_CHECK_EN
    hold_from(2, s0 + 3, 1);
    lit(s0 + 15, 2, 0, 0, 1);
`else
    lit(s0 + 15, 2, 0, 0, 0);
`endif
    lit(s0 + 15, 1, 0, 0, 1);
    lit(s0 + 15, 0, 0, 0, 1);
    lit(s0 + 15, 6, s0 + 9, 0, 1);
    repeat (18) @(negedge clk);

    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cola_buyer.md
COLA_BUYER -- requirements
Module: cola_buyer

Interface
REQ-001 Parameter GAP_CYC, default 1, idle cycles between consecutive coin pulses (0..15; 0 = back-to-back).
REQ-002 Parameter TIMEOUT_CYC, default 4, maximum cycles in WAIT before abort (1..255).
REQ-003 i_sysclk  input  1  single system clock; all logic on rising edge.
REQ-004 i_sysrst  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  one-cycle purchase request; sampled only in IDLE.
REQ-006 i_cups  input  4  colas to buy, latched on accepted start.
REQ-007 i_mode  input  2  payment policy, latched on accepted start: 0 = 1+1+0.5, 1 = 5x0.5, 2 = 1+1+1 (change expected), 3 = treated as 0.
REQ-008 i_cola  input  1  cola-dispensed pulse from vending FSM.
REQ-009 i_money  input  1  0.5-change pulse from vending FSM.
REQ-010 o_money_one  output  1  one-cycle 1-yuan coin pulse to vending FSM.
REQ-011 o_money_half  output  1  one-cycle 0.5-yuan coin pulse to vending FSM.
REQ-012 o_busy  output  1  high from accepted start until DONE.
REQ-013 o_done  output  1  one-cycle completion pulse.
REQ-014 o_err  output  1  sticky error; cleared on next accepted start.
REQ-015 o_cola_cnt  output  4  colas received this purchase.
REQ-016 o_change_cnt  output  4  change pulses received this purchase, saturating at 15.

Function
REQ-017 States IDLE, COIN, GAP, WAIT, NEXT, DONE; all outputs registered.
REQ-018 IDLE: i_start=1 latches cups/mode, clears counters and o_err; i_cups=0 -> DONE, otherwise -> COIN.
REQ-019 COIN drives exactly one coin pulse for one cycle per the mode sequence; o_money_one and o_money_half are never high together.
REQ-020 After a non-last coin: GAP for GAP_CYC cycles, then COIN; GAP_CYC=0 skips GAP. After the last coin of a cup: WAIT.
REQ-021 First coin appears on the cycle after the start-accept edge.
REQ-022 WAIT: i_cola=1 increments o_cola_cnt -> NEXT; TIMEOUT_CYC cycles without i_cola sets o_err -> DONE (abort).
REQ-023 NEXT: o_cola_cnt = cups -> DONE, else coin index resets -> COIN.
REQ-024 DONE: o_done=1 for one cycle, o_busy=0 -> IDLE; o_cola_cnt/o_change_cnt hold until next accepted start.
REQ-025 i_money=1 in any non-IDLE state increments o_change_cnt (saturating).
REQ-026 i_start while busy is ignored.

Reset
REQ-027 i_sysrst=1 at an edge forces IDLE and all outputs to 0, including mid-purchase; no coin pulse follows the release.

Configuration
REQ-028 Macro COLA_BUYER_CHECK_EN defined: set o_err on any of the following.
- i_cola outside WAIT while busy.
- Mode 2 without i_money within WAIT through the cycle after i_cola.
- Mode 0/1 with any i_money.
REQ-029 Macro absent: only timeout sets o_err; counters behave identically.

Structure
REQ-030 Package cola_buyer_pkg holds the following.
- State encoding.
- Mode encodings.
- Per-mode coin sequences and lengths.
- Price constant (5 half-units).
REQ-031 One sub-module, cola_buyer_timer: loadable down-counter serving both GAP and WAIT, with an expire output.

Verification
REQ-032 mode 0, cups 1, GAP 1, vending model dispenses 1 cycle after last coin -> coins one,-,one,-,half; cola_cnt 1, change 0, done, err 0.
REQ-033 mode 2, cups 2, model returns cola+money together -> 6 one-coins, cola_cnt 2, change_cnt 2, err 0.
REQ-034 mode 1, cups 1, model never dispenses -> 5 half-coins, err=1 TIMEOUT_CYC cycles after the last coin, done, cola_cnt 0.
REQ-035 cups 0 -> done 2 cycles after start, no coin pulses, busy high 1 cycle.
REQ-036 i_sysrst asserted after the 2nd coin of cups 3 -> all outputs 0 next cycle; a fresh start then runs cleanly.
REQ-037 With COLA_BUYER_CHECK_EN, mode 0 plus a spurious i_money -> err=1 while the purchase still completes; without the macro, err=0.
